// File: rtl/bcd_iteration_selector.sv
// bcd_iteration_selector
// Operator-entry stage for the Fibonacci datapath. It holds a two-digit
// packed-BCD iteration count that inc/dec buttons step up or down. Holding a
// button auto-repeats after an initial hold delay.
//
// Ports
//   clk_i             system clock, rising edge
//   reset_ni          asynchronous active-low reset
//   inc_i, dec_i      debounced button levels, synchronous to clk_i
//   iterations_bcd_o  count, [7:4] tens digit, [3:0] ones digit
//   changed_o         one-cycle pulse in the cycle the count takes a new value
//   at_limit_o        high while the count sits at MIN_VALUE or MAX_VALUE
module bcd_iteration_selector #(
    parameter int MIN_VALUE     = 0,
    parameter int MAX_VALUE     = 99,
    parameter int WRAP          = 0,
    parameter int HOLD_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       inc_i,
    input  logic       dec_i,
    output logic [7:0] iterations_bcd_o,
    output logic       changed_o,
    output logic       at_limit_o
);

    localparam int TIMER_MAX = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
    localparam int TW        = $clog2(TIMER_MAX + 1);

    localparam logic [7:0]    MIN_BCD     = {4'(MIN_VALUE / 10), 4'(MIN_VALUE % 10)};
    localparam logic [7:0]    MAX_BCD     = {4'(MAX_VALUE / 10), 4'(MAX_VALUE % 10)};
    localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_DELAY - 1);
    localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_PERIOD - 1);
    localparam logic [TW-1:0] TIMER_ONE   = TW'(1);
    localparam logic [TW-1:0] TIMER_ZERO  = TW'(0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_REPEAT  = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    // Packed-BCD increment; the tens digit never overflows because the limit
    // rule intercepts a step at MAX_VALUE before this is used.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Packed-BCD decrement; the tens digit never underflows for the same reason.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd0) begin
            r = {v[7:4] - 4'd1, 4'd9};
        end else begin
            r = {v[7:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    count_q, count_d;
    logic          changed_q, changed_d;
    logic          dir_q, dir_d;          // 1: active button is inc
    logic          inc_hist_q, inc_hist_d;
    logic          dec_hist_q, dec_hist_d;
    logic          armed_q, armed_d;      // low only for the first clock after reset

    logic inc_rise_s, dec_rise_s, active_s, other_s, step_s, step_up_s;

    // Rising-edge detection, masked on the first clock after reset release so a
    // button already held at that moment is not taken as a press.
    always_comb begin
        inc_rise_s = armed_q & inc_i & ~inc_hist_q;
        dec_rise_s = armed_q & dec_i & ~dec_hist_q;
        active_s   = dir_q ? inc_i : dec_i;
        other_s    = dir_q ? dec_i : inc_i;
        inc_hist_d = inc_i;
        dec_hist_d = dec_i;
        armed_d    = 1'b1;
    end

    // FSM next state, hold/repeat timer and step request.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        dir_d     = dir_q;
        step_s    = 1'b0;
        step_up_s = dir_q;
        case (state_q)
            ST_IDLE: begin
                if (inc_rise_s && dec_rise_s) begin
                    state_d = ST_LOCKOUT;
                end else if (inc_rise_s ^ dec_rise_s) begin
                    step_s    = 1'b1;
                    step_up_s = inc_rise_s;
                    dir_d     = inc_rise_s;
                    timer_d   = TIMER_ZERO;
                    state_d   = ST_HOLD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD, ST_REPEAT: begin
                // The opposite button wins over everything, including a timer
                // expiry in the same cycle, so stepping stops immediately.
                if (other_s) begin
                    timer_d = TIMER_ZERO;
                    state_d = ST_LOCKOUT;
                end else if (!active_s) begin
                    timer_d = TIMER_ZERO;
                    state_d = ST_IDLE;
                end else if (timer_q == ((state_q == ST_HOLD) ? HOLD_LAST : REPEAT_LAST)) begin
                    step_s  = 1'b1;
                    timer_d = TIMER_ZERO;
                    state_d = ST_REPEAT;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            ST_LOCKOUT: begin
                timer_d = TIMER_ZERO;
                if (!inc_i && !dec_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LOCKOUT;
                end
            end
            default: begin
                timer_d = TIMER_ZERO;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Count update with limit handling; a saturated step leaves the count as is
    // and therefore raises no changed pulse.
    always_comb begin
        count_d = count_q;
        if (step_s) begin
            if (step_up_s) begin
                if (count_q == MAX_BCD) begin
                    count_d = (WRAP != 0) ? MIN_BCD : count_q;
                end else begin
                    count_d = bcd_inc(count_q);
                end
            end else begin
                if (count_q == MIN_BCD) begin
                    count_d = (WRAP != 0) ? MAX_BCD : count_q;
                end else begin
                    count_d = bcd_dec(count_q);
                end
            end
        end else begin
            count_d = count_q;
        end
        changed_d = (count_d != count_q);
    end

    // State, timer, count and history registers.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= ST_IDLE;
            timer_q    <= TIMER_ZERO;
            count_q    <= MIN_BCD;
            changed_q  <= 1'b0;
            dir_q      <= 1'b0;
            inc_hist_q <= 1'b0;
            dec_hist_q <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            count_q    <= count_d;
            changed_q  <= changed_d;
            dir_q      <= dir_d;
            inc_hist_q <= inc_hist_d;
            dec_hist_q <= dec_hist_d;
            armed_q    <= armed_d;
        end
    end

    assign iterations_bcd_o = count_q;
    assign changed_o        = changed_q;
    assign at_limit_o       = (count_q == MIN_BCD) || (count_q == MAX_BCD);

endmodule
